// File: rtl/imem_arb_pkg.sv
// Purpose: shared types and constants for the instruction-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: requester enum, STARVE_LIMIT default, starvation counter width.
package imem_arb_pkg;

  // Which requester owns the memory address bus this cycle.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_FETCH = 2'd1,
    REQ_DEBUG = 2'd2
  } req_sel_e;

  // Consecutive denied debug cycles tolerated before debug is forced through.
  localparam int STARVE_LIMIT_DEF = 4;

  // Counter width; holds any limit in 1..15.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/imem_arb_starve.sv
// Purpose: saturating count of denied debug-request cycles and the force-grant flag.
// Latency: count updates one cycle after the request/grant it observes; override is combinational in d_req_i.
// Backpressure: none; it only observes the request/grant handshake.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   d_req_i     - debug request level
//   d_gnt_i     - debug grant issued this cycle
//   override_o  - debug must win arbitration this cycle
module imem_arb_starve
  import imem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d_req_i,
  input  logic d_gnt_i,
  output logic override_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Override only matters while debug is still asking; a stale saturated
  // count with d_req low must not steal the bus from fetch.
  assign override_o = d_req_i && (cnt_q == LIMIT_C);

  always_comb begin
    cnt_d = cnt_q;
    if (!d_req_i || d_gnt_i) begin
      // A drop or a win both end the current wait.
      cnt_d = '0;
    end else if (cnt_q != LIMIT_C) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_arb.sv
// Purpose: two-port arbiter (fetch priority, debug anti-starvation) in front of a combinational instruction memory.
// Latency: grant and ia are combinational; read data and valid appear exactly one cycle after the grant.
// Backpressure: requesters hold req until gnt; responses are single-cycle pulses with no stall.
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   f_req/f_addr/f_gnt      - fetch request, byte address, accept strobe
//   f_valid/f_data          - fetch response
//   d_req/d_addr/d_gnt      - debug/loader request, byte address, accept strobe
//   d_valid/d_data          - debug response
//   ia/id                   - memory address out, memory data in (combinational in ia)
module imem_arb
  import imem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_data,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_data,
  output logic [31:0] ia,
  input  logic [31:0] id
);

  logic     override;
  req_sel_e sel;

  logic        f_vld_q, f_vld_d;
  logic [31:0] f_dat_q, f_dat_d;
  logic        d_vld_q, d_vld_d;
  logic [31:0] d_dat_q, d_dat_d;

  imem_arb_starve #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .d_req_i    (d_req),
    .d_gnt_i    (d_gnt),
    .override_o (override)
  );

  // Fetch wins unless debug has waited long enough; nothing is granted in reset.
  always_comb begin
    sel = REQ_NONE;
    if (!reset) begin
      if (d_req && (!f_req || override)) begin
        sel = REQ_DEBUG;
      end else if (f_req) begin
        sel = REQ_FETCH;
      end
    end
  end

  assign f_gnt = (sel == REQ_FETCH);
  assign d_gnt = (sel == REQ_DEBUG);

  // Idle bus parks on the fetch address so the next fetch sees no extra mux delay.
  assign ia = (sel == REQ_DEBUG) ? d_addr : f_addr;

  // Capture the memory word for whoever was granted; the other port's data holds.
  always_comb begin
    f_vld_d = f_gnt;
    f_dat_d = f_gnt ? id : f_dat_q;
    d_vld_d = d_gnt;
    d_dat_d = d_gnt ? id : d_dat_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_vld_q <= 1'b0;
      f_dat_q <= '0;
      d_vld_q <= 1'b0;
      d_dat_q <= '0;
    end else begin
      f_vld_q <= f_vld_d;
      f_dat_q <= f_dat_d;
      d_vld_q <= d_vld_d;
      d_dat_q <= d_dat_d;
    end
  end

  // Outputs are masked while reset is high so a response launched by the
  // last pre-reset grant never reaches the port.
  assign f_valid = f_vld_q && !reset;
  assign f_data  = reset ? '0 : f_dat_q;
  assign d_valid = d_vld_q && !reset;
  assign d_data  = reset ? '0 : d_dat_q;

endmodule

// File: tb/tb_imem_arb.sv
module tb_imem_arb;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [31:0] f_data;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_data;
  logic [31:0] ia;
  logic [31:0] id;

  logic [31:0] mem [0:63];

  int n_cmp;
  int n_bad;

  // Reference model state: a plain wait count plus the response each port shows.
  int          m_wait;
  logic        m_fv;
  logic [31:0] m_fd;
  logic        m_dv;
  logic [31:0] m_dd;
  logic        obs_fg;
  logic        obs_dg;

  imem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset   (reset),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_valid (f_valid),
    .f_data  (f_data),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_gnt   (d_gnt),
    .d_valid (d_valid),
    .d_data  (d_data),
    .ia      (ia),
    .id      (id)
  );

  // Memory strips the supervisor bit and word-aligns: index from ia[7:2].
  assign id = mem[ia[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare every output against the model mid-cycle, then advance the model.
  task automatic cyc();
    logic        e_dg, e_fg;
    logic [31:0] e_ia;
    @(negedge clk);
    e_dg = !reset && d_req && (!f_req || m_wait == LIMIT);
    e_fg = !reset && f_req && !e_dg;
    e_ia = e_dg ? d_addr : f_addr;
    obs_fg = f_gnt;
    obs_dg = d_gnt;
    chk("f_gnt",   {31'd0, f_gnt},   {31'd0, e_fg});
    chk("d_gnt",   {31'd0, d_gnt},   {31'd0, e_dg});
    chk("ia",      ia,               e_ia);
    chk("f_valid", {31'd0, f_valid}, {31'd0, m_fv && !reset});
    chk("f_data",  f_data,           reset ? 32'd0 : m_fd);
    chk("d_valid", {31'd0, d_valid}, {31'd0, m_dv && !reset});
    chk("d_data",  d_data,           reset ? 32'd0 : m_dd);
    if (reset) begin
      m_wait = 0;
      m_fv = 1'b0; m_fd = '0;
      m_dv = 1'b0; m_dd = '0;
    end else begin
      m_fv = e_fg;
      if (e_fg) m_fd = mem[e_ia[7:2]];
      m_dv = e_dg;
      if (e_dg) m_dd = mem[e_ia[7:2]];
      if (!d_req || e_dg) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    n_cmp = 0;
    n_bad = 0;
    m_wait = 0;
    m_fv = 1'b0; m_fd = '0; m_dv = 1'b0; m_dd = '0;
    obs_fg = 1'b0; obs_dg = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    // Reset with both requests up: no grants, cleared outputs.
    reset = 1'b1;
    f_req = 1'b1; f_addr = 32'h0000_0040;
    d_req = 1'b1; d_addr = 32'h0000_0044;
    repeat (3) cyc();
    reset = 1'b0;
    f_req = 1'b0; d_req = 1'b0;
    cyc();

    // Sequential fetches 0x0, 0x4, 0x8.
    for (int k = 0; k < 3; k++) begin
      f_req = 1'b1; f_addr = 32'(k * 4);
      cyc();
      chk("seq_fgnt", {31'd0, obs_fg}, 32'd1);
    end
    f_req = 1'b0;
    cyc();
    chk("seq_last_word", f_data, mem[2]);

    // Debug-only access with the supervisor bit set.
    d_req = 1'b1; d_addr = 32'h8000_0010;
    cyc();
    chk("dbg_gnt", {31'd0, obs_dg}, 32'd1);
    d_req = 1'b0;
    cyc();
    chk("dbg_word", d_data, mem[4]);

    // Continuous contention: four fetch grants, then a forced debug grant.
    f_req = 1'b1; f_addr = 32'h0000_0020;
    d_req = 1'b1; d_addr = 32'h8000_0030;
    for (int k = 0; k < 15; k++) begin
      cyc();
      chk("starve_pat", {31'd0, obs_dg}, {31'd0, (k % 5) == 4});
    end

    // Reset the cycle after a fetch grant: the response is dropped.
    f_req = 1'b0; d_req = 1'b0;
    cyc();
    f_req = 1'b1; f_addr = 32'h0000_0008;
    cyc();
    f_req = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("rst_fvalid", {31'd0, f_valid}, 32'd0);
    chk("rst_fdata",  f_data, 32'd0);

    // Two denied debug cycles, a drop, then a full wait before the forced grant.
    f_req = 1'b1; f_addr = 32'h0000_0010;
    d_req = 1'b1; d_addr = 32'h0000_0014;
    cyc(); cyc();
    d_req = 1'b0;
    cyc();
    d_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("redo_wait", {31'd0, obs_dg}, {31'd0, k == 4});
    end

    // Idle for ten cycles: outputs hold.
    f_req = 1'b0; d_req = 1'b0; f_addr = 32'h0000_00A4;
    cyc();
    w = f_data;
    repeat (10) cyc();
    chk("idle_fdata_hold", f_data, w);

    // Randomized traffic: requests mostly held until granted, occasional
    // abandonment and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 99) == 0) reset = 1'b1;
      if (!f_req || obs_fg || $urandom_range(0, 19) == 0) begin
        f_req = ($urandom_range(0, 3) != 0);
        f_addr = $urandom;
      end
      if (!d_req || obs_dg || $urandom_range(0, 19) == 0) begin
        d_req = ($urandom_range(0, 2) == 0);
        d_addr = $urandom;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, the number of consecutive denied debug-request cycles before the debug port is force-granted (legal range 1..15).
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous active-high reset.
REQ-005 Port: f_req  in  1  fetch-port read request, held until granted.
REQ-006 Port: f_addr  in  32  fetch byte address, supervisor bit included.
REQ-007 Port: f_gnt  out  1  fetch request accepted this cycle (combinational).
REQ-008 Port: f_valid  out  1  fetch response valid.
REQ-009 Port: f_data  out  32  fetch instruction word.
REQ-010 Port: d_req  in  1  debug/loader read request, held until granted.
REQ-011 Port: d_addr  in  32  debug byte address.
REQ-012 Port: d_gnt  out  1  debug request accepted this cycle (combinational).
REQ-013 Port: d_valid  out  1  debug response valid.
REQ-014 Port: d_data  out  32  debug instruction word.
REQ-015 Port: ia  out  32  address to the instruction memory.
REQ-016 Port: id  in  32  memory data, combinational in ia.

Function
REQ-017 The block SHALL grant at most one requester per cycle, and SHALL never assert f_gnt and d_gnt together.
REQ-018 Fetch SHALL have priority: grant fetch when f_req=1 and the starvation override is inactive.
REQ-019 Grant debug when d_req=1 and either f_req=0 or the starvation override is active.
REQ-020 Starvation override is active when starve_cnt==STARVE_LIMIT and d_req=1.
REQ-021 starve_cnt counter:
- increments each cycle in which d_req=1 and d_gnt=0;
- saturates at STARVE_LIMIT;
- clears on a cycle with d_gnt=1;
- clears on a cycle with d_req=0.
REQ-022 ia SHALL equal the granted requester's address unmodified; when nothing is granted, ia SHALL equal f_addr. Supervisor-bit masking and word alignment are the memory's job.
REQ-023 Response latency is exactly 1 cycle: on a grant cycle, register id into the granted port's data register and set that port's valid for the next cycle only.
REQ-024 A port's data output SHALL hold its last value while its valid is 0.
REQ-025 Back-to-back grants to the same port SHALL give valid=1 on consecutive cycles, each cycle carrying the data for the matching request.
REQ-026 A requester deasserting req without a grant SHALL cause no memory access and no response.
REQ-027 Simultaneous f_req and d_req with starve_cnt<STARVE_LIMIT: fetch is granted and starve_cnt increments.
REQ-028 Simultaneous f_req and d_req with override active: debug is granted, starve_cnt clears, and fetch retries next cycle.

Reset
REQ-029 While reset=1:
- f_valid=0, d_valid=0;
- f_data=0, d_data=0;
- starve_cnt=0;
- f_gnt=0, d_gnt=0 regardless of requests.
REQ-030 Reset asserted mid-operation SHALL discard any response that would have been presented in the following cycle; the first grant is possible in the first cycle after reset deasserts.

Structure
REQ-031 Shared package imem_arb_pkg SHALL hold:
- the requester enum (REQ_NONE, REQ_FETCH, REQ_DEBUG);
- the STARVE_LIMIT default;
- the starve_cnt width constant (4 bits).
REQ-032 One sub-module, imem_arb_starve, SHALL implement the saturating starvation counter and the override flag; everything else is in imem_arb.

Verification
REQ-033 Fetch only, sequential addresses 0x0, 0x4, 0x8 on consecutive cycles -> f_gnt=1 each cycle; f_valid=1 one cycle later with words for memory indices 0, 1, 2; d_valid stays 0.
REQ-034 Debug only, d_addr=0x80000010 -> d_gnt=1 and ia=0x80000010 in the same cycle; the next cycle d_valid=1 with the word for index 4.
REQ-035 Continuous f_req plus d_req, STARVE_LIMIT=4 -> fetch granted 4 cycles, debug granted on the 5th cycle, then fetch again; the pattern repeats every 5 cycles.
REQ-036 Reset pulsed on the cycle after a fetch grant -> f_valid=0 on the following cycle, f_data=0, starve_cnt=0.
REQ-037 d_req raised for 2 contended cycles then dropped, then raised again -> starve_cnt returns to 0 on the drop; a forced grant occurs only after 4 further denied cycles.
REQ-038 Both idle -> ia=f_addr, both valids 0, both data outputs unchanged across 10 cycles.
